genetic_filter_array: RTL and testbench

GENETIC_FILTER_ARRAY -- requirements
Module: genetic_filter_array

---
 rtl/genetic_filter_pkg.sv | 15 +
 rtl/filter_channel.sv | 83 ++++++++
 rtl/genetic_filter_array.sv | 52 +++++
 tb/tb_genetic_filter_array.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/genetic_filter_pkg.sv
// Shared types and defaults for the
// debounced sensor/actuator filter array.
package genetic_filter_pkg;

  typedef enum logic [1:0] {
    OFF,
    RISE,
    ON,
    FALL
  } ch_state_e;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_DELAY = 5;

endpackage

// File: rtl/filter_channel.sv
// One channel: actuator follows the set/clear
// condition only after DELAY consecutive samples.
module filter_channel
  import genetic_filter_pkg::*;
#(
  parameter int unsigned DELAY  = DEF_DELAY,
  parameter bit          STICKY = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic sensor_i,
  output logic act_o
);

  localparam int unsigned CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] DLY = CW'(DELAY);
  localparam logic [CW-1:0] ONE = CW'(1);

  ch_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          act_q;

  logic          set_c;
  logic          clr_c;
  logic [CW-1:0] cnt_inc;

  // Sticky mode ignores the sensor when clearing.
  assign set_c   = start_i & sensor_i;
  assign clr_c   = STICKY ? ~start_i
                          : ~start_i & ~sensor_i;
  assign cnt_inc = cnt_q + ONE;
  assign act_o   = act_q;

  // Channel FSM; counter holds run length of
  // the pending condition, never reaching DELAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      unique case (state_q)
        OFF, RISE: begin
          if (set_c) begin
            if (cnt_inc == DLY) begin
              state_q <= ON;
              cnt_q   <= '0;
              act_q   <= 1'b1;
            end else begin
              state_q <= RISE;
              cnt_q   <= cnt_inc;
            end
          end else begin
            state_q <= OFF;
            cnt_q   <= '0;
          end
        end
        ON, FALL: begin
          if (clr_c) begin
            if (cnt_inc == DLY) begin
              state_q <= OFF;
              cnt_q   <= '0;
              act_q   <= 1'b0;
            end else begin
              state_q <= FALL;
              cnt_q   <= cnt_inc;
            end
          end else begin
            state_q <= ON;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= OFF;
          cnt_q   <= '0;
          act_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/genetic_filter_array.sv
// Array of independent filter channels plus a
// registered count of active actuators.
module genetic_filter_array
  import genetic_filter_pkg::*;
#(
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned DELAY  = DEF_DELAY,
  parameter bit          STICKY = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Start,
  input  logic [N_CH-1:0]           Sensor,
  output logic [N_CH-1:0]           Actuator,
  output logic [$clog2(N_CH+1)-1:0] ActiveCount
);

  localparam int unsigned AW = $clog2(N_CH + 1);

  logic [AW-1:0] pop_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    filter_channel #(
      .DELAY (DELAY),
      .STICKY(STICKY)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (Start),
      .sensor_i(Sensor[g]),
      .act_o   (Actuator[g])
    );
  end

  // Population count of the current actuators.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      pop_d = pop_d + AW'(Actuator[i]);
    end
  end

  // Count lags Actuator by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ActiveCount <= '0;
    end else begin
      ActiveCount <= pop_d;
    end
  end

endmodule

// File: tb/tb_genetic_filter_array.sv
// Bench: three configurations driven in parallel
// and compared against a run-length model.
module tb_genetic_filter_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Sensor = 4'b0000;

  logic [3:0] a0, a1, a2;
  logic [2:0] c0, c1, c2;

  int checks = 0;
  int passed = 0;
  int fails = 0;

  int         md[3] = '{5, 5, 1};
  bit         ms[3] = '{1'b0, 1'b1, 1'b0};
  int         run[3][4];
  logic [3:0] mact[3];
  logic [2:0] mac[3];

  always #5 clk = ~clk;

  genetic_filter_array #(
    .N_CH(4), .DELAY(5), .STICKY(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .Sensor(Sensor), .Actuator(a0),
    .ActiveCount(c0)
  );

  genetic_filter_array #(
    .N_CH(4), .DELAY(5), .STICKY(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .Sensor(Sensor), .Actuator(a1),
    .ActiveCount(c1)
  );

  genetic_filter_array #(
    .N_CH(4), .DELAY(1), .STICKY(1'b0)
  ) dut_d1 (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .Sensor(Sensor), .Actuator(a2),
    .ActiveCount(c2)
  );

  function automatic logic [3:0] get_act(int k);
    case (k)
      0: return a0;
      1: return a1;
      default: return a2;
    endcase
  endfunction

  function automatic logic [2:0] get_cnt(int k);
    case (k)
      0: return c0;
      1: return c1;
      default: return c2;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mact[k] = 4'b0000;
      mac[k]  = 3'd0;
      for (int i = 0; i < 4; i++) run[k][i] = 0;
    end
  endtask

  // Actuator flips after md consecutive samples of
  // the opposing condition; count shows old value.
  task automatic model_update(input logic st,
                              input logic [3:0] sn);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] old;
      old = mact[k];
      for (int i = 0; i < 4; i++) begin
        bit setc, clrc, want;
        setc = st && sn[i];
        clrc = ms[k] ? !st : (!st && !sn[i]);
        want = old[i] ? clrc : setc;
        if (want) run[k][i]++;
        else run[k][i] = 0;
        if (run[k][i] == md[k]) begin
          mact[k][i] = ~old[i];
          run[k][i] = 0;
        end
      end
      mac[k] = 3'($countones(old));
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.act%0d", tag, k),
            32'(get_act(k)), 32'(mact[k]));
      check($sformatf("%s.cnt%0d", tag, k),
            32'(get_cnt(k)), 32'(mac[k]));
    end
  endtask

  task automatic step(input string tag,
                      input logic st,
                      input logic [3:0] sn);
    Start  = st;
    Sensor = sn;
    @(posedge clk);
    model_update(st, sn);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_act", 32'(a0), 32'h0);
    check("rst_cnt", 32'(c0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single channel rise after five samples
    for (int n = 0; n < 4; n++) step("r29", 1, 4'b0001);
    check("r29_pre", 32'(a0), 32'h0);
    step("r29", 1, 4'b0001);
    check("r29_on", 32'(a0), 32'h1);
    check("r29_cnt0", 32'(c0), 32'h0);
    step("r29", 1, 4'b0001);
    check("r29_cnt1", 32'(c0), 32'h1);

    // Broken run restarts the count
    for (int n = 0; n < 4; n++) step("r30", 1, 4'b0011);
    step("r30", 1, 4'b0001);
    for (int n = 0; n < 4; n++) step("r30", 1, 4'b0011);
    check("r30_pre", 32'(a0[1]), 32'h0);
    step("r30", 1, 4'b0011);
    check("r30_on", 32'(a0[1]), 32'h1);

    // All on, then simultaneous clear
    for (int n = 0; n < 5; n++) step("r31", 1, 4'b1111);
    check("r31_all", 32'(a0), 32'hf);
    step("r31", 1, 4'b1111);
    for (int n = 0; n < 4; n++) step("r31", 0, 4'b0000);
    check("r31_hold", 32'(a0), 32'hf);
    step("r31", 0, 4'b0000);
    check("r31_off", 32'(a0), 32'h0);
    check("r31_c4", 32'(c0), 32'h4);
    step("r31", 0, 4'b0000);
    check("r31_c0", 32'(c0), 32'h0);

    // Sticky vs non-sticky clear with sensor high
    for (int n = 0; n < 5; n++) step("r32", 1, 4'b1111);
    for (int n = 0; n < 5; n++) step("r32", 0, 4'b0001);
    check("r32_nst", 32'(a0), 32'h1);
    check("r32_st", 32'(a1), 32'h0);

    // Reset in the middle of a fall
    for (int n = 0; n < 5; n++) step("r33", 1, 4'b1111);
    step("r33", 1, 4'b1111);
    for (int n = 0; n < 3; n++) step("r33", 0, 4'b0000);
    check("r33_pre", 32'(a0), 32'hf);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("r33_act", 32'(a0), 32'h0);
    check("r33_cnt", 32'(c0), 32'h0);
    compare_all("r33rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) step("r33", 1, 4'b1111);
    check("r33_wait", 32'(a0), 32'h0);
    step("r33", 1, 4'b1111);
    check("r33_on", 32'(a0), 32'hf);

    // Single-sample delay configuration
    step("r34", 0, 4'b0000);
    step("r34", 1, 4'b1010);
    check("r34_act", 32'(a2), 32'ha);
    step("r34", 1, 4'b1010);
    check("r34_cnt", 32'(c2), 32'h2);

    // Random inputs that tend to persist
    for (int n = 0; n < 400; n++) begin
      logic       st;
      logic [3:0] sn;
      st = Start;
      sn = Sensor;
      if ($urandom_range(3) == 0) st = ~st;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5) == 0) sn[i] = ~sn[i];
      step("rand", st, sn);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
